bcd_counter_mn: RTL and testbench

Parametrised multi-digit BCD modulo-N counter with built-in prescaler, up/down counting, synchronous load and per-digit 7-segment decode. It generalises the single-digit mod-10 display counter: it sits between the board clock/KEY reset and the HEX display outputs, and also serves as a reusable timebase/event counter inside the design.

---
 rtl/bcd_counter_mn.sv | 155 +++++++++++++++
 tb/tb_bcd_counter_mn.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mn.sv
// Multi-digit BCD modulo-N counter with prescaler, up/down stepping, checked
// synchronous load and per-digit active-low 7-segment decode.
module bcd_counter_mn #(
  parameter int     DIGITS   = 2,
  parameter longint MODULUS  = 60,
  parameter int     TICK_DIV = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  KEY_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  tick,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Elaboration-time conversion only; the running count stays in BCD.
  function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
    longint r;
    logic [4*DIGITS-1:0] b;
    r = v;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] count_reg, count_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic                tick_reg, tick_next;
  logic                wrap_reg, wrap_next;
  logic                load_err_reg, load_err_next;

  logic [4*DIGITS-1:0] inc_val, dec_val;
  logic [DIGITS-1:0]   carry, borrow, digit_ok;
  logic                load_ok;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Ripple carry/borrow digit by digit: a digit changes only when every
  // lower digit rolls over (9 -> 0 going up, 0 -> 9 going down).
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur = count_reg[4*gi +: 4];

      assign inc_val[4*gi +: 4] = !carry[gi]   ? cur :
                                  (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      assign dec_val[4*gi +: 4] = !borrow[gi]  ? cur :
                                  (cur == 4'd0) ? 4'd9 : cur - 4'd1;

      if (gi < DIGITS - 1) begin : g_chain
        assign carry[gi+1]  = carry[gi]  & (cur == 4'd9);
        assign borrow[gi+1] = borrow[gi] & (cur == 4'd0);
      end

      assign digit_ok[gi]      = (load_val[4*gi +: 4] <= 4'd9);
      assign HEX[7*gi +: 7]    = seg7(cur);
    end
  endgenerate

  // With all digits valid, unsigned order of the packed BCD equals numeric order.
  assign load_ok = (&digit_ok) && (load_val <= MAX_BCD);

  always_comb begin
    count_next    = count_reg;
    presc_next    = presc_reg;
    tick_next     = 1'b0;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_next = load_val;
        presc_next = '0;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (en) begin
      if (presc_reg == PRESC_LAST) begin
        presc_next = '0;
        tick_next  = 1'b1;
        if (up) begin
          if (count_reg == MAX_BCD) begin
            count_next = '0;
            wrap_next  = 1'b1;
          end else begin
            count_next = inc_val;
          end
        end else begin
          if (count_reg == '0) begin
            count_next = MAX_BCD;
            wrap_next  = 1'b1;
          end else begin
            count_next = dec_val;
          end
        end
      end else begin
        presc_next = presc_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY_n) begin
    if (!KEY_n) begin
      count_reg    <= '0;
      presc_reg    <= '0;
      tick_reg     <= 1'b0;
      wrap_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      presc_reg    <= presc_next;
      tick_reg     <= tick_next;
      wrap_reg     <= wrap_next;
      load_err_reg <= load_err_next;
    end
  end

  assign bcd      = count_reg;
  assign tick     = tick_reg;
  assign wrap     = wrap_reg;
  assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_counter_mn.sv
// Directed bench for bcd_counter_mn (2 digits, mod 60, step every 4 cycles);
// inputs change and outputs are checked on the falling clock edge.
module tb_bcd_counter_mn;

  logic        tb_CLOCK_50;
  logic        KEY_n;
  logic        en;
  logic        up;
  logic        load;
  logic [7:0]  load_val;
  logic [7:0]  bcd;
  logic [13:0] HEX;
  logic        tick;
  logic        wrap;
  logic        load_err;

  int n_assert = 0;
  int n_fail   = 0;

  bcd_counter_mn #(
    .DIGITS   (2),
    .MODULUS  (60),
    .TICK_DIV (4)
  ) dut (
    .CLOCK_50 (tb_CLOCK_50),
    .KEY_n    (KEY_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .HEX      (HEX),
    .tick     (tick),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial begin
    tb_CLOCK_50 = 1'b0;
    forever #5 tb_CLOCK_50 = ~tb_CLOCK_50;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge tb_CLOCK_50);
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge tb_CLOCK_50);
    load     = 1'b0;
  endtask

  initial begin
    KEY_n    = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    cyc(2);
    chk("rst_bcd",      32'(bcd),      32'h00);
    chk("rst_hex",      32'(HEX),      32'(14'b0000001_0000001));
    chk("rst_tick",     32'(tick),     32'h0);
    chk("rst_wrap",     32'(wrap),     32'h0);
    chk("rst_load_err", 32'(load_err), 32'h0);

    // Release: first step comes 4 enabled cycles later
    KEY_n = 1'b1;
    cyc(3);
    chk("pre_step_bcd",  32'(bcd),  32'h00);
    chk("pre_step_tick", 32'(tick), 32'h0);
    cyc(1);
    chk("step1_bcd",  32'(bcd),  32'h01);
    chk("step1_tick", 32'(tick), 32'h1);
    cyc(1);
    chk("step1_tick_low", 32'(tick), 32'h0);
    cyc(3);
    chk("step2_bcd",  32'(bcd),  32'h02);
    chk("step2_tick", 32'(tick), 32'h1);

    // Up wrap 58 -> 59 -> 00
    do_load(8'h58);
    chk("ld58_bcd", 32'(bcd), 32'h58);
    cyc(4);
    chk("up59_bcd",  32'(bcd),  32'h59);
    chk("up59_wrap", 32'(wrap), 32'h0);
    chk("up59_hex",  32'(HEX),  32'(14'b0100100_0000100));
    cyc(4);
    chk("wrap00_bcd",  32'(bcd),  32'h00);
    chk("wrap00_wrap", 32'(wrap), 32'h1);
    chk("wrap00_tick", 32'(tick), 32'h1);
    cyc(1);
    chk("wrap_pulse_low", 32'(wrap), 32'h0);

    // Digit carry 09 -> 10
    do_load(8'h09);
    cyc(4);
    chk("carry_bcd",  32'(bcd),  32'h10);
    chk("carry_wrap", 32'(wrap), 32'h0);

    // Down wrap 00 -> 59 and borrow 10 -> 09
    up = 1'b0;
    do_load(8'h00);
    cyc(4);
    chk("dn_wrap_bcd",  32'(bcd),  32'h59);
    chk("dn_wrap_wrap", 32'(wrap), 32'h1);
    do_load(8'h10);
    cyc(4);
    chk("borrow_bcd",  32'(bcd),  32'h09);
    chk("borrow_wrap", 32'(wrap), 32'h0);

    // Load while a step is due wins, restarts the prescaler
    up = 1'b1;
    do_load(8'h20);
    cyc(3);
    do_load(8'h47);
    chk("ld47_bcd",  32'(bcd),  32'h47);
    chk("ld47_tick", 32'(tick), 32'h0);
    chk("ld47_wrap", 32'(wrap), 32'h0);
    chk("ld47_hex",  32'(HEX),  32'(14'b1001100_0001111));
    cyc(3);
    chk("ld47_hold_bcd", 32'(bcd), 32'h47);
    cyc(1);
    chk("ld47_next_bcd",  32'(bcd),  32'h48);
    chk("ld47_next_tick", 32'(tick), 32'h1);

    // Rejected load 0x60 (out of range) with step due
    cyc(3);
    do_load(8'h60);
    chk("rej60_err",  32'(load_err), 32'h1);
    chk("rej60_bcd",  32'(bcd),      32'h48);
    chk("rej60_tick", 32'(tick),     32'h0);
    cyc(1);
    chk("rej60_err_low", 32'(load_err), 32'h0);
    chk("rej60_after_bcd", 32'(bcd),    32'h49);

    // Rejected load 0x3A (non-BCD digit) with step due
    cyc(3);
    do_load(8'h3A);
    chk("rej3a_err",  32'(load_err), 32'h1);
    chk("rej3a_bcd",  32'(bcd),      32'h49);
    chk("rej3a_tick", 32'(tick),     32'h0);
    cyc(1);
    chk("rej3a_err_low",   32'(load_err), 32'h0);
    chk("rej3a_after_bcd", 32'(bcd),      32'h50);

    // Freeze with en low after 2 prescaler counts
    cyc(2);
    en = 1'b0;
    cyc(10);
    chk("frz_bcd",  32'(bcd),  32'h50);
    chk("frz_tick", 32'(tick), 32'h0);
    en = 1'b1;
    cyc(1);
    chk("resume1_bcd", 32'(bcd), 32'h50);
    cyc(1);
    chk("resume2_bcd",  32'(bcd),  32'h51);
    chk("resume2_tick", 32'(tick), 32'h1);

    // Asynchronous reset mid-count
    do_load(8'h33);
    cyc(2);
    chk("pre_rst_bcd", 32'(bcd), 32'h33);
    #2 KEY_n = 1'b0;
    #1;
    chk("async_rst_bcd", 32'(bcd), 32'h00);
    chk("async_rst_hex", 32'(HEX), 32'(14'b0000001_0000001));
    @(negedge tb_CLOCK_50);
    KEY_n = 1'b1;
    cyc(3);
    chk("post_rst_hold_bcd", 32'(bcd), 32'h00);
    cyc(1);
    chk("post_rst_step_bcd", 32'(bcd), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
